memory_controller: RTL and testbench
====================================

# memory_controller

Single-outstanding memory controller between `memory_accessor` and the on-chip synchronous word RAM. It accepts one byte-addressed request (read, or write when write data accompanies the address), drives the RAM port for exactly one cycle and waits out the RAM read latency. It then returns one 32-bit response word per request through a valid/ready channel. Out-of-range addresses are not issued to the RAM; they are flagged instead.

## Interface
Parameters:
- `ADDR_WIDTH`, 12: RAM word-address width. RAM holds 2^ADDR_WIDTH 32-bit words.
- `READ_LATENCY`, 2: cycles from the RAM enable cycle to valid `RAM_RDATA`. Legal range is 1..7.

Ports:
- `CLK`  in  1: clock. All logic on the rising edge.
- `RST`  in  1: reset. Asynchronous, active-low.
- `RECEIVE_ADDR_VALID`  in  1: request valid.
- `RECEIVE_ADDR`  in  32: byte address.
- `RECEIVE_DATA_VALID`  in  1: write request, qualified by `RECEIVE_ADDR_VALID`.
- `RECEIVE_DATA`  in  32: write data.
- `RECEIVE_READY`  out  1: request ready.
- `SEND_VALID`  out  1: response valid.
- `SEND_DATA`  out  32: response word.
- `SEND_READY`  in  1: response ready.
- `RAM_EN`  out  1: RAM access strobe.
- `RAM_WE`  out  1: RAM write enable, qualified by `RAM_EN`.
- `RAM_ADDR`  out  ADDR_WIDTH: word address.
- `RAM_WDATA`  out  32: write data.
- `RAM_RDATA`  in  32: read data.
- `OOR_FLAG`  out  1: sticky out-of-range indicator. Cleared only by reset.

## Operation
- FSM states and transitions:
  - S_IDLE → S_ISSUE on a request handshake when the address is in range.
  - S_IDLE → S_RESP on a request handshake when the address is out of range.
  - S_ISSUE → S_WAIT for a read, or → S_RESP for a write.
  - S_WAIT → S_RESP when the latency counter expires.
  - S_RESP → S_IDLE on a response handshake.
- Request handshake is `RECEIVE_ADDR_VALID && RECEIVE_READY`. At the handshake, capture the address, `RECEIVE_DATA_VALID` as a write flag, and `RECEIVE_DATA`. A later `RECEIVE_DATA_VALID` without a new handshake is ignored.
- Word index is `RECEIVE_ADDR[ADDR_WIDTH+1:2]`. Bits [1:0] are ignored: a misaligned access is truncated to the containing word.
- Out of range means `RECEIVE_ADDR[31:ADDR_WIDTH+2] != 0`. For such a request:
  - no RAM cycle is issued;
  - `OOR_FLAG` is set;
  - the response is 32'h0 for both read and write.
- S_ISSUE: `RAM_EN`=1 for exactly one cycle. `RAM_WE` equals the write flag. `RAM_ADDR` and `RAM_WDATA` come from the captured values.
- S_WAIT: a 3-bit counter loads READ_LATENCY-1 and decrements. When the counter is 0, register `RAM_RDATA` into `SEND_DATA` and go to S_RESP.
- Response data:
  - read: the RAM word;
  - in-range write: the written data, echoed;
  - out of range: 0.
- `SEND_DATA` stays stable while `SEND_VALID`=1.
- Exactly one response per accepted request. There is never more than one request outstanding.

## Timing
- Values while `RST`=0, all forced asynchronously: `RECEIVE_READY`=0, `SEND_VALID`=0, `SEND_DATA`=0, `RAM_EN`=0, `RAM_WE`=0, `RAM_ADDR`=0, `RAM_WDATA`=0, `OOR_FLAG`=0, state S_IDLE.
- First cycle after reset release: `RECEIVE_READY`=1.
- `RECEIVE_READY` is registered. It is 1 only in S_IDLE and falls in the cycle after the handshake.
- Cycle numbering below takes the handshake in cycle T.
- In-range read:
  - `RAM_EN`=1 in T+1;
  - `RAM_RDATA` is sampled in T+1+READ_LATENCY;
  - `SEND_VALID`=1 from T+2+READ_LATENCY.
- In-range write: `RAM_EN`=`RAM_WE`=1 in T+1, and `SEND_VALID`=1 from T+2.
- Out-of-range access: `SEND_VALID`=1 from T+1. `OOR_FLAG` is 1 from T+1.
- `SEND_VALID` holds until `SEND_READY`=1. `SEND_READY` low for N cycles stretches S_RESP by N cycles.
- Back-to-back requests: after the response handshake in cycle R, `RECEIVE_READY`=1 in R+1. The next handshake is therefore no earlier than R+1.
- Reset asserted mid-transaction: state is abandoned, no response is emitted, and `RAM_EN` drops immediately.

## Test plan
- Write then read: write addr 0x10 / data 0xCAFEF00D. Expect `RAM_EN`=`RAM_WE`=1 at T+1 with `RAM_ADDR`=4, then response 0xCAFEF00D. A following read of 0x10 returns 0xCAFEF00D at T+2+READ_LATENCY (T+4 with default).
- Misaligned read of 0x13, following that write: `RAM_ADDR`=4, response 0xCAFEF00D.
- Out of range, read addr 0x4000 with default ADDR_WIDTH: no `RAM_EN`, response 0 at T+1, `OOR_FLAG`=1 and still 1 after 10 further in-range accesses.
- Backpressure: `SEND_READY` held 0 for 5 cycles during a read response. `SEND_VALID`/`SEND_DATA` stay stable and `RECEIVE_READY` stays 0 until the handshake.
- Latency sweep with READ_LATENCY=1 and 7: response timing is exactly T+2+READ_LATENCY in both builds.
- Reset mid-read: `RST`=0 during S_WAIT clears all outputs immediately. After release, no stale response appears and a new read completes normally.

Source files
------------

// File: rtl/memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : memory_controller
// Description : Single-outstanding controller between a request/response
//               client and an on-chip synchronous 32-bit word RAM. Takes one
//               byte-addressed read or write, issues a single RAM cycle, waits
//               out the RAM read latency and returns one response word.
//               Out-of-range requests never reach the RAM; they answer 0 and
//               set a sticky flag.
// Ports       : CLK, RST (async, active-low)
//               RECEIVE_* : request channel (address, optional write data)
//               SEND_*    : response channel (valid/ready, 32-bit word)
//               RAM_*     : RAM port (strobe, write enable, word address, data)
//               OOR_FLAG  : sticky out-of-range indicator, cleared by reset
// Revision    : 1.0 - initial release
// ============================================================================
module memory_controller #(
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RECEIVE_ADDR_VALID,
  input  logic [31:0]           RECEIVE_ADDR,
  input  logic                  RECEIVE_DATA_VALID,
  input  logic [31:0]           RECEIVE_DATA,
  output logic                  RECEIVE_READY,
  output logic                  SEND_VALID,
  output logic [31:0]           SEND_DATA,
  input  logic                  SEND_READY,
  output logic                  RAM_EN,
  output logic                  RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [31:0]           RAM_WDATA,
  input  logic [31:0]           RAM_RDATA,
  output logic                  OOR_FLAG
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Counter reload: reaching zero marks the cycle RAM_RDATA is valid.
  localparam logic [2:0] C_LAT_LOAD = 3'(READ_LATENCY - 1);

  state_t                  state_q,      state_d;
  logic                    recv_ready_q, recv_ready_d;
  logic                    send_valid_q, send_valid_d;
  logic [31:0]             send_data_q,  send_data_d;
  logic                    ram_en_q,     ram_en_d;
  logic                    ram_we_q,     ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q,   ram_addr_d;
  logic [31:0]             ram_wdata_q,  ram_wdata_d;
  logic                    write_q,      write_d;
  logic                    oor_q,        oor_d;
  logic [2:0]              cnt_q,        cnt_d;

  logic                    req_fire;
  logic                    resp_fire;
  logic                    req_oor;
  logic                    unused_addr_lsbs;

  // Byte-lane bits are dropped: a misaligned access hits its containing word.
  assign unused_addr_lsbs = ^RECEIVE_ADDR[1:0];

  assign req_fire  = RECEIVE_ADDR_VALID && recv_ready_q;
  assign resp_fire = send_valid_q && SEND_READY;
  assign req_oor   = |RECEIVE_ADDR[31:ADDR_WIDTH+2];

  always_comb begin
    state_d     = state_q;
    send_data_d = send_data_q;
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    write_d     = write_q;
    oor_d       = oor_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          write_d = RECEIVE_DATA_VALID;
          if (req_oor) begin
            // Answer directly without touching the RAM.
            oor_d       = 1'b1;
            send_data_d = 32'h0;
            state_d     = S_RESP;
          end else begin
            ram_addr_d  = RECEIVE_ADDR[ADDR_WIDTH+1:2];
            ram_wdata_d = RECEIVE_DATA;
            ram_en_d    = 1'b1;
            ram_we_d    = RECEIVE_DATA_VALID;
            state_d     = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (write_q) begin
          send_data_d = ram_wdata_q;   // writes echo the stored word
          state_d     = S_RESP;
        end else begin
          cnt_d   = C_LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          send_data_d = RAM_RDATA;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      S_RESP: begin
        if (resp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Handshake outputs are registered images of the next state.
    recv_ready_d = (state_d == S_IDLE);
    send_valid_d = (state_d == S_RESP);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= S_IDLE;
      recv_ready_q <= 1'b0;
      send_valid_q <= 1'b0;
      send_data_q  <= 32'h0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= 32'h0;
      write_q      <= 1'b0;
      oor_q        <= 1'b0;
      cnt_q        <= 3'd0;
    end else begin
      state_q      <= state_d;
      recv_ready_q <= recv_ready_d;
      send_valid_q <= send_valid_d;
      send_data_q  <= send_data_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      write_q      <= write_d;
      oor_q        <= oor_d;
      cnt_q        <= cnt_d;
    end
  end

  assign RECEIVE_READY = recv_ready_q;
  assign SEND_VALID    = send_valid_q;
  assign SEND_DATA     = send_data_q;
  assign RAM_EN        = ram_en_q;
  assign RAM_WE        = ram_we_q;
  assign RAM_ADDR      = ram_addr_q;
  assign RAM_WDATA     = ram_wdata_q;
  assign OOR_FLAG      = oor_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_controller
// Description : Scoreboard bench for memory_controller. Three instances with
//               read latencies 2, 1 and 7, each with its own RAM model.
//               Expected response words are queued at request time and a
//               monitor pops and compares them on each response handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_controller;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } sb_entry_t;

  logic        clk;
  logic        rst_n;

  logic        av    [3];
  logic [31:0] addr  [3];
  logic        dv    [3];
  logic [31:0] wdat  [3];
  logic        rdy   [3];
  logic        sv    [3];
  logic [31:0] sd    [3];
  logic        sr    [3];
  logic        en    [3];
  logic        we    [3];
  logic [11:0] raddr [3];
  logic [31:0] rwd   [3];
  logic [31:0] rdata [3];
  logic        oor   [3];

  sb_entry_t   sb_q [$];
  sb_entry_t   mon_e;
  int          n_vec, n_err;
  int          mon_vec, mon_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 7);
    logic [31:0] mem  [0:4095];
    logic [31:0] pipe [0:LAT-1];

    memory_controller #(.ADDR_WIDTH(12), .READ_LATENCY(LAT)) u_dut (
      .CLK                (clk),
      .RST                (rst_n),
      .RECEIVE_ADDR_VALID (av[g]),
      .RECEIVE_ADDR       (addr[g]),
      .RECEIVE_DATA_VALID (dv[g]),
      .RECEIVE_DATA       (wdat[g]),
      .RECEIVE_READY      (rdy[g]),
      .SEND_VALID         (sv[g]),
      .SEND_DATA          (sd[g]),
      .SEND_READY         (sr[g]),
      .RAM_EN             (en[g]),
      .RAM_WE             (we[g]),
      .RAM_ADDR           (raddr[g]),
      .RAM_WDATA          (rwd[g]),
      .RAM_RDATA          (rdata[g]),
      .OOR_FLAG           (oor[g])
    );

    // Synchronous RAM: read word appears LAT cycles after the enable cycle;
    // a marker value is shown otherwise so mistimed sampling is visible.
    always @(posedge clk) begin
      if (en[g] && we[g]) mem[raddr[g]] <= rwd[g];
      pipe[0] <= (en[g] && !we[g]) ? mem[raddr[g]] : 32'hDEAD_BEEF;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata[g] = pipe[LAT-1];
  end

  // Response monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (sv[i] && sr[i]) begin
        mon_vec++;
        if (sb_q.size() == 0) begin
          mon_err++;
          $display("FAIL unexpected_resp dut%0d: got 0x%08h, expected no response", i, sd[i]);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.id != 2'(i) || sd[i] !== mon_e.data) begin
            mon_err++;
            $display("FAIL resp_data dut%0d: got 0x%08h, expected 0x%08h from dut%0d",
                     i, sd[i], mon_e.data, mon_e.id);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present a request and return one step after its handshake edge (cycle T+1).
  task automatic do_req(input int i, input logic [31:0] a, input logic wr, input logic [31:0] d);
    int n;
    n = 0;
    av[i] = 1'b1; addr[i] = a; dv[i] = wr; wdat[i] = d;
    while (!rdy[i] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rdy[i]) begin
      n_vec++; n_err++;
      $display("FAIL req_ready_timeout dut%0d: ready 0, expected 1", i);
    end
    @(posedge clk); #1;
    av[i] = 1'b0; dv[i] = 1'b0; addr[i] = 32'h0; wdat[i] = 32'h0;
  endtask

  // Full transaction: queue expectation, check the RAM cycle in T+1, and
  // check the cycle (relative to T) at which SEND_VALID first appears.
  task automatic txn(input int i, input logic [31:0] a, input logic wr, input logic [31:0] d,
                     input logic [31:0] exp_d, input logic is_oor, input logic [11:0] exp_addr,
                     input int exp_lat);
    int k;
    sb_q.push_back('{id: 2'(i), data: exp_d});
    do_req(i, a, wr, d);
    @(negedge clk);
    if (is_oor) begin
      chk("oor_no_ram_en", 32'(en[i]), 32'h0);
      chk("oor_flag_set", 32'(oor[i]), 32'h1);
    end else begin
      chk("ram_en", 32'(en[i]), 32'h1);
      chk("ram_we", 32'(we[i]), 32'(wr));
      chk("ram_addr", 32'(raddr[i]), 32'(exp_addr));
      if (wr) chk("ram_wdata", rwd[i], d);
    end
    k = 1;
    while (!sv[i] && k < 30) begin
      @(negedge clk);
      k++;
    end
    chk("resp_latency", 32'(k), 32'(exp_lat));
  endtask

  initial begin
    int n;
    int seen;
    n_vec = 0; n_err = 0; mon_vec = 0; mon_err = 0;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      av[i] = 1'b0; addr[i] = 32'h0; dv[i] = 1'b0; wdat[i] = 32'h0; sr[i] = 1'b1;
    end

    // Reset values.
    #12;
    chk("rst_ready", 32'(rdy[0]), 32'h0);
    chk("rst_send_valid", 32'(sv[0]), 32'h0);
    chk("rst_send_data", sd[0], 32'h0);
    chk("rst_ram_en", 32'(en[0]), 32'h0);
    chk("rst_ram_we", 32'(we[0]), 32'h0);
    chk("rst_ram_addr", 32'(raddr[0]), 32'h0);
    chk("rst_ram_wdata", rwd[0], 32'h0);
    chk("rst_oor", 32'(oor[0]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(rdy[0]), 32'h1);

    // Write then read, misaligned read, second word.
    txn(0, 32'h10, 1'b1, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 12'h004, 2);
    txn(0, 32'h10, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0, 12'h004, 4);
    txn(0, 32'h13, 1'b0, 32'h0,        32'hCAFE_F00D, 1'b0, 12'h004, 4);
    txn(0, 32'h20, 1'b1, 32'h1234_5678, 32'h1234_5678, 1'b0, 12'h008, 2);
    txn(0, 32'h20, 1'b0, 32'h0,        32'h1234_5678, 1'b0, 12'h008, 4);

    // Out of range read and write both answer 0 at T+1.
    txn(0, 32'h4000,      1'b0, 32'h0,        32'h0, 1'b1, 12'h000, 1);
    txn(0, 32'hFFFF_FFF0, 1'b1, 32'h5555_AAAA, 32'h0, 1'b1, 12'h000, 1);

    // Ten in-range accesses; the flag must stay set.
    for (int j = 0; j < 10; j++) begin
      if (j % 2 == 0)
        txn(0, 32'h200 + 32'(j) * 4, 1'b1, 32'h1000_0000 + 32'(j), 32'h1000_0000 + 32'(j),
            1'b0, 12'h080 + 12'(j), 2);
      else
        txn(0, 32'h10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 12'h004, 4);
    end
    @(negedge clk);
    chk("oor_sticky", 32'(oor[0]), 32'h1);

    // Backpressure: response held for five cycles.
    @(posedge clk); #1;
    sr[0] = 1'b0;
    txn(0, 32'h20, 1'b0, 32'h0, 32'h1234_5678, 1'b0, 12'h008, 4);
    for (int j = 0; j < 5; j++) begin
      chk("bp_send_valid", 32'(sv[0]), 32'h1);
      chk("bp_send_data", sd[0], 32'h1234_5678);
      chk("bp_ready_low", 32'(rdy[0]), 32'h0);
      @(posedge clk); #1;
    end
    sr[0] = 1'b1;

    // Latency sweep on the latency-1 and latency-7 instances.
    txn(1, 32'h40, 1'b1, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 12'h010, 2);
    txn(1, 32'h40, 1'b0, 32'h0,         32'hA5A5_0001, 1'b0, 12'h010, 3);
    txn(2, 32'h44, 1'b1, 32'h5A5A_0007, 32'h5A5A_0007, 1'b0, 12'h011, 2);
    txn(2, 32'h44, 1'b0, 32'h0,         32'h5A5A_0007, 1'b0, 12'h011, 9);

    // Reset while dut0 waits on the RAM: nothing queued for this read.
    @(posedge clk); #1;
    do_req(0, 32'h10, 1'b0, 32'h0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_ram_en", 32'(en[0]), 32'h0);
    chk("midrst_send_valid", 32'(sv[0]), 32'h0);
    chk("midrst_ready", 32'(rdy[0]), 32'h0);
    chk("midrst_send_data", sd[0], 32'h0);
    chk("midrst_ram_addr", 32'(raddr[0]), 32'h0);
    chk("midrst_oor_cleared", 32'(oor[0]), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (sv[0]) seen = 1;
    end
    chk("no_stale_resp", 32'(seen), 32'h0);
    txn(0, 32'h10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 12'h004, 4);

    // Drain the scoreboard.
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL sb_drain: %0d responses missing, expected 0", sb_q.size());
    end
    repeat (2) @(posedge clk);

    n_vec = n_vec + mon_vec;
    n_err = n_err + mon_err;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
